// File: rtl/rc_servo_pkg.sv
// rc_servo_pkg: shared timing constants and decoder state encoding for R/C servo blocks
package rc_servo_pkg;
  localparam int CLK_DIV       = 98;
  localparam int TICKS_PER_MS  = 256;
  localparam int ZERO_TICKS    = TICKS_PER_MS;
  localparam int MIN_TICKS     = 128;
  localparam int MAX_TICKS     = 768;
  localparam int FRAME_TIMEOUT = 6400;
  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE
  } state_t;
endpackage

// File: rtl/rc_tick_gen.sv
// rc_tick_gen: prescaler producing a one-cycle tick every DIV clocks, with synchronous clear
module rc_tick_gen
  import rc_servo_pkg::*;
#(
  parameter int DIV = CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);
  logic [6:0] r_cnt;
  assign o_tick = (r_cnt == 7'(DIV - 1));
  // count 0..DIV-1 and wrap; a clear restarts the period so the next tick is DIV clocks away
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 7'd1;
  end
endmodule

// File: rtl/rc_servo_pulse_decoder.sv
// rc_servo_pulse_decoder: measures R/C servo pulse width in ticks and maps it to an 8-bit position
module rc_servo_pulse_decoder
  import rc_servo_pkg::*;
#(
  parameter int CLK_DIV       = rc_servo_pkg::CLK_DIV,
  parameter int MIN_TICKS     = rc_servo_pkg::MIN_TICKS,
  parameter int ZERO_TICKS    = rc_servo_pkg::ZERO_TICKS,
  parameter int MAX_TICKS     = rc_servo_pkg::MAX_TICKS,
  parameter int FRAME_TIMEOUT = rc_servo_pkg::FRAME_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  output logic [7:0] pos,
  output logic       pos_valid,
  output logic       pulse_err,
  output logic       signal_lost
);
  localparam logic [10:0] L_MIN  = 11'(MIN_TICKS);
  localparam logic [10:0] L_ZERO = 11'(ZERO_TICKS);
  localparam logic [10:0] L_FULL = 11'(ZERO_TICKS + 256);
  localparam logic [10:0] L_MAX  = 11'(MAX_TICKS);
  localparam logic [12:0] L_TO   = 13'(FRAME_TIMEOUT);

  logic r_sync1, r_sync2, r_prev, r_rise, r_fall;
  state_t r_state, w_next;
  logic [9:0] r_width;
  logic [12:0] r_to;
  logic r_lost, r_valid, r_err;
  logic [7:0] r_pos;
  logic w_tick, w_clr, w_valid, w_err;
  logic [10:0] w_eff;
  logic [7:0] w_pos;

  rc_tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  // a tick landing in the fall cycle completes the last period, so it counts toward the width
  assign w_eff = {1'b0, r_width} + {10'd0, w_tick};
  assign w_pos = (w_eff < L_ZERO) ? 8'd0 : (w_eff >= L_FULL) ? 8'hFF : w_eff[7:0] - L_ZERO[7:0];

  // two-flop synchronizer, previous-value flop, and registered edge strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
      r_fall  <= ~r_sync2 & r_prev;
    end
  end

  // decoder state register
  always_ff @(posedge clk) begin
    r_state <= rst ? WAIT_LOW : w_next;
  end

  // next state and decode strobes; an overlong width wins over a coincident fall
  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_valid = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      WAIT_LOW: w_next = r_sync2 ? WAIT_LOW : WAIT_RISE;
      WAIT_RISE: begin
        w_clr  = r_rise;
        w_next = r_rise ? MEASURE : WAIT_RISE;
      end
      MEASURE: begin
        if (w_eff >= L_MAX) begin
          w_err  = 1'b1;
          w_next = WAIT_LOW;
        end else if (r_fall) begin
          w_valid = (w_eff >= L_MIN);
          w_err   = (w_eff < L_MIN);
          w_next  = WAIT_RISE;
        end
      end
      default: w_next = WAIT_LOW;
    endcase
  end

  // width counter advances one per tick while measuring
  always_ff @(posedge clk) begin
    if (rst || w_clr) r_width <= '0;
    else if (r_state == MEASURE && w_tick) r_width <= r_width + 10'd1;
  end

  // registered outputs; pos only moves on a valid decode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_valid;
      r_err   <= w_err;
      if (w_valid) r_pos <= w_pos;
    end
  end

  // frame timeout: saturating tick count since the last valid decode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to   <= '0;
      r_lost <= 1'b1;
    end else if (w_valid) begin
      r_to   <= '0;
      r_lost <= 1'b0;
    end else if (w_tick && r_to != L_TO) begin
      r_to   <= r_to + 13'd1;
      r_lost <= r_lost | (r_to == L_TO - 13'd1);
    end
  end

  assign pos         = r_pos;
  assign pos_valid   = r_valid;
  assign pulse_err   = r_err;
  assign signal_lost = r_lost;
endmodule

// File: tb/tb_rc_servo_pulse_decoder.sv
// tb_rc_servo_pulse_decoder: directed pulses with a scoreboard of expected decode events
module tb_rc_servo_pulse_decoder;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse_in = 1'b0;
  logic [7:0] pos;
  logic pos_valid, pulse_err, signal_lost;

  typedef struct {
    bit         err;
    logic [7:0] pos;
    int         t;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int last_valid = -1;

  rc_servo_pulse_decoder #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .pulse_err  (pulse_err),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // drive a high pulse of ticks*D clocks and queue the event the decoder must report
  task automatic pulse(input int ticks, input bit err, input logic [7:0] p);
    int c0;
    @(posedge clk);
    #1 pulse_in = 1'b1;
    c0 = cyc;
    if (ticks >= 768) sb.push_back('{1'b1, p, c0 + 4 + D * 768});
    repeat (ticks * D) @(posedge clk);
    #1 pulse_in = 1'b0;
    if (ticks < 768) sb.push_back('{err, p, cyc + 4});
    repeat (200) @(posedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pos"}, int'(pos), 0);
    chk({tag, "_valid"}, int'(pos_valid), 0);
    chk({tag, "_err"}, int'(pulse_err), 0);
    chk({tag, "_lost"}, int'(signal_lost), 1);
  endtask

  // monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (pos_valid || pulse_err)) begin
      chk("exclusive", int'(pos_valid && pulse_err), 0);
      if (sb.size() == 0) chk("unexpected_event", sb.size(), 1);
      else begin
        e_cur = sb.pop_front();
        chk("kind_err", int'(pulse_err), int'(e_cur.err));
        chk("pos", int'(pos), int'(e_cur.pos));
        chk("event_cycle", cyc, e_cur.t);
        if (pos_valid) begin
          chk("lost_clear_on_valid", int'(signal_lost), 0);
          last_valid = cyc;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, dt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    repeat (10) @(posedge clk);
    pulse(375, 1'b0, 8'd119);
    chk("lost_after_first", int'(signal_lost), 0);
    pulse(256, 1'b0, 8'd0);
    pulse(511, 1'b0, 8'd255);
    pulse(512, 1'b0, 8'd255);
    pulse(75, 1'b1, 8'd255);
    chk("pos_retained", int'(pos), 255);
    pulse(127, 1'b1, 8'd255);
    pulse(128, 1'b0, 8'd0);
    pulse(300, 1'b0, 8'd44);
    pulse(767, 1'b0, 8'd255);
    pulse(1024, 1'b1, 8'd255);
    pulse(375, 1'b0, 8'd119);
    pulse(375, 1'b0, 8'd119);
    t0 = last_valid;
    for (int i = 0; i < 6400 * D + 50 && !signal_lost; i++) @(negedge clk);
    dt = cyc - t0;
    chk("lost_set", int'(signal_lost), 1);
    chk("lost_window", int'(dt >= 6399 * D + 1 && dt <= 6400 * D), 1);
    pulse(375, 1'b0, 8'd119);
    @(posedge clk);
    #1 rst = 1'b1;
    pulse_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("high_at_reset");
    repeat (300 * D) @(posedge clk);
    #1 pulse_in = 1'b0;
    repeat (200) @(posedge clk);
    pulse(306, 1'b0, 8'd50);
    @(posedge clk);
    #1 pulse_in = 1'b1;
    repeat (200 * D) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_measure");
    repeat (175 * D) @(posedge clk);
    #1 pulse_in = 1'b0;
    repeat (200) @(posedge clk);
    pulse(375, 1'b0, 8'd119);
    repeat (50) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
